// File: rtl/carry_save_adder_reg_pkg.sv
// ============================================================================
// Module : csa_pkg
// Brief  : Shared width default and vector type for the carry-save adder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package csa_pkg;

  localparam int CSA_WIDTH_DEFAULT = 8;

  typedef logic [CSA_WIDTH_DEFAULT-1:0] csa_vec_t;

endpackage : csa_pkg

`default_nettype wire

// File: rtl/carry_save_adder_reg_if.sv
// ============================================================================
// Module : carry_save_adder_reg_if
// Brief  : Operand/result bundle for carry_save_adder_reg. The sum field is
//          present only when CSA_FINAL_ADD_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface carry_save_adder_reg_if
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH_DEFAULT
);

  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] z;
  logic             out_valid;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] s;
`ifdef CSA_FINAL_ADD_EN
  logic [WIDTH+1:0] sum;
`endif

  modport master (
    output in_valid, x, y, z,
    input  out_valid, c, s
`ifdef CSA_FINAL_ADD_EN
    , input sum
`endif
  );

  modport slave (
    input  in_valid, x, y, z,
    output out_valid, c, s
`ifdef CSA_FINAL_ADD_EN
    , output sum
`endif
  );

endinterface : carry_save_adder_reg_if

`default_nettype wire

// File: rtl/carry_save_adder_reg_cells.sv
// ============================================================================
// Module : full_adder / half_adder
// Brief  : Single-bit adder cells. half_adder exists only for the final-add
//          chain and is built only when CSA_FINAL_ADD_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
  output logic co,
  output logic s,
  input  logic a,
  input  logic b,
  input  logic ci
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule : full_adder

`ifdef CSA_FINAL_ADD_EN
module half_adder (
  output logic c,
  output logic s,
  input  logic a,
  input  logic b
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder
`endif

`default_nettype wire

// File: rtl/carry_save_adder_reg.sv
// ============================================================================
// Module : carry_save_adder_reg
// Brief  : Registered 3:2 carry-save adder (1-cycle latency). Defining
//          CSA_FINAL_ADD_EN adds a ripple final adder producing sum = s+(c<<1).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module carry_save_adder_reg
  import csa_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  carry_save_adder_reg_if.slave bus
);

  logic [WIDTH-1:0] w_c;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] r_c;
  logic [WIDTH-1:0] r_s;
  logic             r_valid;

  for (genvar i = 0; i < WIDTH; i++) begin : g_csa
    full_adder u_fa (
      .co (w_c[i]),
      .s  (w_s[i]),
      .a  (bus.x[i]),
      .b  (bus.y[i]),
      .ci (bus.z[i])
    );
  end

  // Registers load only on accepted triples, so idle-cycle inputs never matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c     <= '0;
      r_s     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_c <= w_c;
        r_s <= w_s;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.c         = r_c;
  assign bus.s         = r_s;

`ifdef CSA_FINAL_ADD_EN
  logic [WIDTH:0]   w_s_ext;
  logic [WIDTH:1]   w_rc;
  logic [WIDTH+1:0] w_sum;

  assign w_s_ext  = {1'b0, r_s};
  assign w_sum[0] = r_s[0];

  half_adder u_ha (
    .c (w_rc[1]),
    .s (w_sum[1]),
    .a (r_s[1]),
    .b (r_c[0])
  );

  // c is unshifted, so bit i pairs s[i] with c[i-1].
  for (genvar i = 2; i <= WIDTH; i++) begin : g_final_add
    full_adder u_fa (
      .co (w_rc[i]),
      .s  (w_sum[i]),
      .a  (w_s_ext[i]),
      .b  (r_c[i-1]),
      .ci (w_rc[i-1])
    );
  end

  assign w_sum[WIDTH+1] = w_rc[WIDTH];
  assign bus.sum        = w_sum;
`endif

endmodule : carry_save_adder_reg

`default_nettype wire

// File: tb/tb_carry_save_adder_reg.sv
// ============================================================================
// Module : tb_carry_save_adder_reg
// Brief  : Directed and randomized checks of carry_save_adder_reg against an
//          arithmetic reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_carry_save_adder_reg;
  import csa_pkg::*;

  localparam int WIDTH = CSA_WIDTH_DEFAULT;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  carry_save_adder_reg_if #(.WIDTH(WIDTH)) bus ();

  carry_save_adder_reg #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: what the outputs should show after the latest edge.
  csa_vec_t m_c;
  csa_vec_t m_s;
  logic     m_v;
  int       m_total;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input csa_vec_t a,
                            input csa_vec_t b, input csa_vec_t d);
    int cnt;
    if (r) begin
      m_c = '0; m_s = '0; m_v = 1'b0; m_total = 0;
    end else if (v) begin
      m_v     = 1'b1;
      m_total = int'(a) + int'(b) + int'(d);
      for (int i = 0; i < WIDTH; i++) begin
        cnt     = int'(a[i]) + int'(b[i]) + int'(d[i]);
        m_s[i]  = (cnt % 2) == 1;
        m_c[i]  = cnt >= 2;
      end
    end else begin
      m_v = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'(m_v));
    chk({tag, ".c"}, 64'(bus.c), 64'(m_c));
    chk({tag, ".s"}, 64'(bus.s), 64'(m_s));
`ifdef CSA_FINAL_ADD_EN
    chk({tag, ".sum"}, 64'(bus.sum), 64'(int'(m_s) + 2 * int'(m_c)));
`endif
  endtask

  // Drive one cycle, clock it, update the model and sample 1ns after the edge.
  task automatic cycle(input logic r, input logic v, input csa_vec_t a,
                       input csa_vec_t b, input csa_vec_t d);
    rst = r; bus.in_valid = v; bus.x = a; bus.y = b; bus.z = d;
    @(posedge clk);
    model_edge(r, v, a, b, d);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_c = '0; m_s = '0; m_v = 1'b0; m_total = 0;
    rst = 1'b1; bus.in_valid = 1'b0; bus.x = '0; bus.y = '0; bus.z = '0;

    cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    chk("reset.valid", 64'(bus.out_valid), 64'd0);
    chk("reset.c", 64'(bus.c), 64'd0);
    chk("reset.s", 64'(bus.s), 64'd0);

    cycle(1'b0, 1'b1, 8'h01, 8'h02, 8'h04);
    chk("case1.valid", 64'(bus.out_valid), 64'd1);
    chk("case1.c", 64'(bus.c), 64'h00);
    chk("case1.s", 64'(bus.s), 64'h07);
`ifdef CSA_FINAL_ADD_EN
    chk("case1.sum", 64'(bus.sum), 64'd7);
`endif

    cycle(1'b0, 1'b1, 8'h55, 8'h33, 8'h0F);
    chk("case2.c", 64'(bus.c), 64'h17);
    chk("case2.s", 64'(bus.s), 64'h69);
`ifdef CSA_FINAL_ADD_EN
    chk("case2.sum", 64'(bus.sum), 64'd151);
`endif

    cycle(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk("case3.c", 64'(bus.c), 64'hFF);
    chk("case3.s", 64'(bus.s), 64'hFF);
`ifdef CSA_FINAL_ADD_EN
    chk("case3.sum", 64'(bus.sum), 64'd765);
`endif

    cycle(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF);
    chk("case4.valid", 64'(bus.out_valid), 64'd0);
    chk("case4.c", 64'(bus.c), 64'd0);
    chk("case4.s", 64'(bus.s), 64'd0);
`ifdef CSA_FINAL_ADD_EN
    chk("case4.sum", 64'(bus.sum), 64'd0);
`endif

    cycle(1'b0, 1'b1, 8'h01, 8'h02, 8'h04);
    chk("case5a.s", 64'(bus.s), 64'h07);
    chk("case5a.valid", 64'(bus.out_valid), 64'd1);
    cycle(1'b0, 1'b1, 8'h55, 8'h33, 8'h0F);
    chk("case5b.c", 64'(bus.c), 64'h17);
    chk("case5b.s", 64'(bus.s), 64'h69);
    cycle(1'b0, 1'b0, 8'hA5, 8'h5A, 8'hC3);
    chk("case5c.valid", 64'(bus.out_valid), 64'd0);
    chk("case5c.c", 64'(bus.c), 64'h17);
    chk("case5c.s", 64'(bus.s), 64'h69);
    cycle(1'b0, 1'b0, 8'hFF, 8'hFF, 8'hFF);
    chk("case5d.c", 64'(bus.c), 64'h17);
    chk("case5d.s", 64'(bus.s), 64'h69);

    for (int k = 0; k < 1000; k++) begin
      cycle(1'b0, ($urandom_range(0, 3) != 0), csa_vec_t'($urandom),
            csa_vec_t'($urandom), csa_vec_t'($urandom));
      check_outputs("rand");
      if (m_v)
        chk("rand.invariant", 64'(int'(bus.s) + 2 * int'(bus.c)), 64'(m_total));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_carry_save_adder_reg

`default_nettype wire
